// File: rtl/mips_instr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mips_instr_pkg                                                |
// | Purpose  : Shared MIPS instruction constants: symbolic op enumeration,   |
// |            primary opcodes, SPECIAL funct codes and word-packing helpers.|
// |            The core's instruction type decoder uses the same constants.  |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package mips_instr_pkg;

  // Symbolic operation; encodings 29..31 are illegal.
  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_SLT   = 5'd4,
    OP_SLTU  = 5'd5,
    OP_ADDI  = 5'd6,
    OP_ANDI  = 5'd7,
    OP_ORI   = 5'd8,
    OP_LUI   = 5'd9,
    OP_LB    = 5'd10,
    OP_LH    = 5'd11,
    OP_LW    = 5'd12,
    OP_SB    = 5'd13,
    OP_SH    = 5'd14,
    OP_SW    = 5'd15,
    OP_MULT  = 5'd16,
    OP_MULTU = 5'd17,
    OP_DIV   = 5'd18,
    OP_DIVU  = 5'd19,
    OP_MFHI  = 5'd20,
    OP_MFLO  = 5'd21,
    OP_MTHI  = 5'd22,
    OP_MTLO  = 5'd23,
    OP_BEQ   = 5'd24,
    OP_BNE   = 5'd25,
    OP_JAL   = 5'd26,
    OP_JR    = 5'd27,
    OP_NOP   = 5'd28
  } op_e;

  // Primary opcodes (instruction bits [31:26]).
  localparam logic [5:0] c_opc_special = 6'h00;
  localparam logic [5:0] c_opc_jal     = 6'h03;
  localparam logic [5:0] c_opc_beq     = 6'h04;
  localparam logic [5:0] c_opc_bne     = 6'h05;
  localparam logic [5:0] c_opc_addi    = 6'h08;
  localparam logic [5:0] c_opc_andi    = 6'h0C;
  localparam logic [5:0] c_opc_ori     = 6'h0D;
  localparam logic [5:0] c_opc_lui     = 6'h0F;
  localparam logic [5:0] c_opc_lb      = 6'h20;
  localparam logic [5:0] c_opc_lh      = 6'h21;
  localparam logic [5:0] c_opc_lw      = 6'h23;
  localparam logic [5:0] c_opc_sb      = 6'h28;
  localparam logic [5:0] c_opc_sh      = 6'h29;
  localparam logic [5:0] c_opc_sw      = 6'h2B;

  // SPECIAL funct codes (instruction bits [5:0]).
  localparam logic [5:0] c_fn_jr    = 6'h08;
  localparam logic [5:0] c_fn_mfhi  = 6'h10;
  localparam logic [5:0] c_fn_mthi  = 6'h11;
  localparam logic [5:0] c_fn_mflo  = 6'h12;
  localparam logic [5:0] c_fn_mtlo  = 6'h13;
  localparam logic [5:0] c_fn_mult  = 6'h18;
  localparam logic [5:0] c_fn_multu = 6'h19;
  localparam logic [5:0] c_fn_div   = 6'h1A;
  localparam logic [5:0] c_fn_divu  = 6'h1B;
  localparam logic [5:0] c_fn_add   = 6'h20;
  localparam logic [5:0] c_fn_sub   = 6'h22;
  localparam logic [5:0] c_fn_and   = 6'h24;
  localparam logic [5:0] c_fn_or    = 6'h25;
  localparam logic [5:0] c_fn_slt   = 6'h2A;
  localparam logic [5:0] c_fn_sltu  = 6'h2B;

  // SPECIAL-format word; shamt is never used by the supported ops.
  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {c_opc_special, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] opcode, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opcode, rs, rt, imm};
  endfunction

  function automatic logic [31:0] pack_j(input logic [5:0] opcode, input logic [25:0] target);
    return {opcode, target};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_word_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_word_encoder                                            |
// | Purpose  : Combinational encoder from symbolic op plus fields to a       |
// |            32-bit MIPS word. Fields the op does not use are forced to 0. |
// | Ports    : i_op[4:0]       symbolic operation (op_e encoding)            |
// |            i_rs/i_rt/i_rd  register fields                               |
// |            i_imm[25:0]     immediate ([15:0] I-type, [25:0] JAL)         |
// |            o_word[31:0]    encoded word (0 when illegal)                 |
// |            o_illegal       op encoding is not a defined operation        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module instr_word_encoder
  import mips_instr_pkg::*;
(
  input  logic [4:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [25:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  op_e         w_op;
  logic [15:0] w_imm16;

  assign w_op    = op_e'(i_op);
  assign w_imm16 = i_imm[15:0];

  always_comb begin
    o_word    = 32'd0;
    o_illegal = 1'b0;
    case (w_op)
      OP_ADD:   o_word = pack_r(i_rs, i_rt, i_rd, c_fn_add);
      OP_SUB:   o_word = pack_r(i_rs, i_rt, i_rd, c_fn_sub);
      OP_AND:   o_word = pack_r(i_rs, i_rt, i_rd, c_fn_and);
      OP_OR:    o_word = pack_r(i_rs, i_rt, i_rd, c_fn_or);
      OP_SLT:   o_word = pack_r(i_rs, i_rt, i_rd, c_fn_slt);
      OP_SLTU:  o_word = pack_r(i_rs, i_rt, i_rd, c_fn_sltu);
      OP_ADDI:  o_word = pack_i(c_opc_addi, i_rs, i_rt, w_imm16);
      OP_ANDI:  o_word = pack_i(c_opc_andi, i_rs, i_rt, w_imm16);
      OP_ORI:   o_word = pack_i(c_opc_ori,  i_rs, i_rt, w_imm16);
      OP_LUI:   o_word = pack_i(c_opc_lui,  5'd0, i_rt, w_imm16);
      OP_LB:    o_word = pack_i(c_opc_lb,   i_rs, i_rt, w_imm16);
      OP_LH:    o_word = pack_i(c_opc_lh,   i_rs, i_rt, w_imm16);
      OP_LW:    o_word = pack_i(c_opc_lw,   i_rs, i_rt, w_imm16);
      OP_SB:    o_word = pack_i(c_opc_sb,   i_rs, i_rt, w_imm16);
      OP_SH:    o_word = pack_i(c_opc_sh,   i_rs, i_rt, w_imm16);
      OP_SW:    o_word = pack_i(c_opc_sw,   i_rs, i_rt, w_imm16);
      // HI/LO ops write no GPR, so rd is zero.
      OP_MULT:  o_word = pack_r(i_rs, i_rt, 5'd0, c_fn_mult);
      OP_MULTU: o_word = pack_r(i_rs, i_rt, 5'd0, c_fn_multu);
      OP_DIV:   o_word = pack_r(i_rs, i_rt, 5'd0, c_fn_div);
      OP_DIVU:  o_word = pack_r(i_rs, i_rt, 5'd0, c_fn_divu);
      OP_MFHI:  o_word = pack_r(5'd0, 5'd0, i_rd, c_fn_mfhi);
      OP_MFLO:  o_word = pack_r(5'd0, 5'd0, i_rd, c_fn_mflo);
      OP_MTHI:  o_word = pack_r(i_rs, 5'd0, 5'd0, c_fn_mthi);
      OP_MTLO:  o_word = pack_r(i_rs, 5'd0, 5'd0, c_fn_mtlo);
      OP_BEQ:   o_word = pack_i(c_opc_beq,  i_rs, i_rt, w_imm16);
      OP_BNE:   o_word = pack_i(c_opc_bne,  i_rs, i_rt, w_imm16);
      OP_JAL:   o_word = pack_j(c_opc_jal,  i_imm);
      OP_JR:    o_word = pack_r(i_rs, 5'd0, 5'd0, c_fn_jr);
      OP_NOP:   o_word = 32'd0;
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_stream_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_stream_encoder                                          |
// | Purpose  : Accepts symbolic instructions over valid/ready, encodes them  |
// |            to MIPS words, buffers them in a DEPTH-entry FIFO and emits   |
// |            them with an auto-incrementing word address.                  |
// | Ports    : clk, rst_n (async, active-low), clear (sync flush)            |
// |            in_valid/in_ready, in_op, in_rs, in_rt, in_rd, in_imm         |
// |            out_valid/out_ready, out_instr, out_addr                      |
// |            err  sticky flag: an illegal op was accepted                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module instr_stream_encoder
  import mips_instr_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [25:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err
);

  localparam int              c_aw       = $clog2(DEPTH);
  localparam logic [c_aw-1:0] c_ptr_one  = c_aw'(1);
  localparam logic [c_aw:0]   c_cnt_one  = (c_aw + 1)'(1);
  localparam logic [c_aw:0]   c_cnt_full = (c_aw + 1)'(DEPTH);

  logic [31:0]     r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic [31:0]     r_addr;
  logic            r_err;

  logic [31:0]     w_word;
  logic            w_illegal;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;

  instr_word_encoder u_enc (
    .i_op      (in_op),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_imm     (in_imm),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // Ready depends on occupancy only: no pop-enables-push bypass when full.
  assign in_ready  = (r_count != c_cnt_full);
  assign out_valid = (r_count != '0);
  assign out_instr = out_valid ? r_mem[r_rd_ptr] : 32'd0;
  assign out_addr  = r_addr;
  assign err       = r_err;

  // clear drops anything handshaken in the same cycle.
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & ~w_illegal & ~clear;
  assign w_pop    = out_valid & out_ready & ~clear;

  // Storage has no reset: out_instr is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= BASE_ADDR;
      r_err    <= 1'b0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= BASE_ADDR;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
        r_addr   <= r_addr + 32'd4;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      if (w_accept && w_illegal) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_stream_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_instr_stream_encoder                                       |
// | Purpose  : Self-checking bench for instr_stream_encoder: directed cases  |
// |            followed by random traffic against a queue-based model.       |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_instr_stream_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready, err;
  logic [4:0]  in_op, in_rs, in_rt, in_rd;
  logic [25:0] in_imm;
  logic [31:0] out_instr, out_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_stream_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference tables indexed by op number: primary opcode, funct, and which
  // fields appear in the word as {rs, rt, rd, imm16, imm26}.
  int unsigned tb_opc [0:28] = '{0, 0, 0, 0, 0, 0, 8, 12, 13, 15, 32, 33, 35, 40, 41, 43,
                                 0, 0, 0, 0, 0, 0, 0, 0, 4, 5, 3, 0, 0};
  int unsigned tb_fn  [0:28] = '{32, 34, 36, 37, 42, 43, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                 24, 25, 26, 27, 16, 18, 17, 19, 0, 0, 0, 8, 0};
  bit [4:0]    tb_use [0:28] = '{5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b11100,
                                 5'b11010, 5'b11010, 5'b11010, 5'b01010,
                                 5'b11010, 5'b11010, 5'b11010, 5'b11010, 5'b11010, 5'b11010,
                                 5'b11000, 5'b11000, 5'b11000, 5'b11000,
                                 5'b00100, 5'b00100, 5'b10000, 5'b10000,
                                 5'b11010, 5'b11010, 5'b00001, 5'b10000, 5'b00000};

  // Model state.
  logic [31:0] mq [$];
  logic [31:0] m_addr;
  logic        m_err;

  // Returns {illegal, word}.
  function automatic logic [32:0] ref_enc(int op, int rs, int rt, int rd, int imm);
    longint w;
    bit [4:0] u;
    if (op > 28) return {1'b1, 32'd0};
    u = tb_use[op];
    w = longint'(tb_opc[op]) * 64'd67108864 + longint'(tb_fn[op]);
    if (u[4]) w += longint'(rs) * 2097152;
    if (u[3]) w += longint'(rt) * 65536;
    if (u[2]) w += longint'(rd) * 2048;
    if (u[1]) w += longint'(imm % 65536);
    if (u[0]) w += longint'(imm % 67108864);
    return {1'b0, w[31:0]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] head;
    head = (mq.size() != 0) ? mq[0] : 32'd0;
    chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("out_instr", out_instr, head);
    chk("out_addr",  out_addr,  m_addr);
    chk("err",       32'(err),  32'(m_err));
  endtask

  task automatic model_reset();
    mq.delete();
    m_addr = BASE;
    m_err  = 1'b0;
  endtask

  // Called at a falling edge with inputs settled: check, then advance one clock.
  task automatic cycle();
    logic [32:0] e;
    int sz;
    check_outputs();
    sz = mq.size();
    e  = ref_enc(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_imm));
    @(posedge clk);
    if (clear) begin
      model_reset();
    end else begin
      if (sz > 0 && out_ready) begin
        void'(mq.pop_front());
        m_addr += 32'd4;
      end
      if (in_valid && sz < DEPTH) begin
        if (e[32]) m_err = 1'b1;
        else       mq.push_back(e[31:0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic set_in(int op, int rs, int rt, int rd, int imm);
    in_valid = 1'b1;
    in_op    = 5'(op);
    in_rs    = 5'(rs);
    in_rt    = 5'(rt);
    in_rd    = 5'(rd);
    in_imm   = 26'(imm);
  endtask

  // Accept one instruction, check the literal word/address one cycle later, pop it.
  task automatic directed(string tag, int op, int rs, int rt, int rd, int imm,
                          logic [31:0] exp_word, logic [31:0] exp_addr);
    out_ready = 1'b0;
    set_in(op, rs, rt, rd, imm);
    cycle();
    in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_word"},  out_instr, exp_word);
    chk({tag, "_addr"},  out_addr,  exp_addr);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    cycle();

    // Encodings from the test plan.
    directed("add",  0,  1,  2, 3, 0,      32'h0022_1820, 32'h0000_3000);
    directed("ori",  8,  0,  1, 0, 'h1234, 32'h3401_1234, 32'h0000_3004);
    directed("lui",  9,  7,  2, 0, 'hFFFF, 32'h3C02_FFFF, 32'h0000_3008);
    directed("sw",   15, 29, 31, 0, 'hFFFC, 32'hAFBF_FFFC, 32'h0000_300C);
    directed("jal",  26, 0,  0, 0, 'h0C00, 32'h0C00_0C00, 32'h0000_3010);
    directed("jr",   27, 31, 0, 0, 0,      32'h03E0_0008, 32'h0000_3014);
    directed("mflo", 21, 0,  0, 8, 0,      32'h0000_4012, 32'h0000_3018);
    directed("nop",  28, 9,  9, 9, 'h3FF_FFFF, 32'h0000_0000, 32'h0000_301C);

    clear = 1'b1;
    cycle();
    clear = 1'b0;
    cycle();

    // Fill to DEPTH with consumer stalled, then a 5th word waits.
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_in(0, k, k, k, 0);
      cycle();
    end
    set_in(1, 5, 6, 7, 0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cycle();
    chk("full_hold_addr", out_addr, 32'h0000_3000);
    out_ready = 1'b1;
    cycle();
    chk("drain_addr1", out_addr, 32'h0000_3004);
    cycle();
    in_valid = 1'b0;
    chk("drain_addr2", out_addr, 32'h0000_3008);
    cycle();
    chk("drain_addr3", out_addr, 32'h0000_300C);
    cycle();
    chk("drain_addr4", out_addr, 32'h0000_3010);
    chk("drain_word5", out_instr, 32'h00A6_3822);
    cycle();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Illegal op: handshake completes, nothing pushed, sticky err.
    set_in(30, 1, 2, 3, 4);
    chk("illegal_ready", 32'(in_ready), 32'd1);
    cycle();
    in_valid = 1'b0;
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_noout", 32'(out_valid), 32'd0);
    cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("clear_err", 32'(err), 32'd0);
    chk("clear_addr", out_addr, 32'h0000_3000);
    chk("clear_empty", 32'(out_valid), 32'd0);

    // clear in the same cycle as a push and a pop.
    out_ready = 1'b0;
    set_in(2, 3, 4, 5, 0); cycle();
    set_in(3, 6, 7, 8, 0); cycle();
    out_ready = 1'b1;
    clear = 1'b1;
    cycle();
    clear = 1'b0; in_valid = 1'b0;
    cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 2) != 0);
      clear     = 1'($urandom_range(0, 39) == 0);
      in_op     = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(29, 31))
                                               : 5'($urandom_range(0, 28));
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_imm    = 26'($urandom);
      cycle();
    end
    clear = 1'b0;

    // Asynchronous reset with words buffered and err set.
    out_ready = 1'b0;
    set_in(30, 0, 0, 0, 0); cycle();
    for (int k = 0; k < 3; k++) begin
      set_in(6, k, k + 1, 0, k * 100);
      cycle();
    end
    in_valid = 1'b0;
    check_outputs();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_addr",  out_addr,  BASE);
    chk("arst_instr", out_instr, 32'd0);
    chk("arst_err",   32'(err),  32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_in(4, 10, 11, 12, 0);
    cycle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_stream_encoder.md
# instr_stream_encoder

Sequential MIPS instruction encoder, the inverse of the core's instruction type decoder. It accepts symbolic instructions (operation code plus register and immediate fields) over a valid/ready handshake. It encodes each one into a 32-bit MIPS word, buffers it in a small FIFO, and presents it with an auto-incrementing word address for writing into instruction memory. Self-test and program-loader paths use it to build instruction streams without a software assembler.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- BASE_ADDR, 32'h0000_3000, address of the first emitted word
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- clear  in  1  synchronous flush: empties the FIFO, sets address to BASE_ADDR, clears err
- in_valid  in  1  input instruction valid
- in_ready  out  1  input accepted when in_valid & in_ready
- in_op  in  5  operation enum (values 0–28 legal, 29–31 illegal)
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  26  immediate; bits [15:0] for I-type, all 26 bits for JAL
- out_valid  out  1  head word available
- out_ready  in  1  consumer accepts the word when out_valid & out_ready
- out_instr  out  32  encoded word; 0 when out_valid=0
- out_addr  out  32  address for out_instr
- err  out  1  sticky; an illegal op was accepted

## Operation
- Op enum order: ADD SUB AND OR SLT SLTU ADDI ANDI ORI LUI LB LH LW SB SH SW MULT MULTU DIV DIVU MFHI MFLO MTHI MTLO BEQ BNE JAL JR NOP. ADD=0, NOP=28.
- R-type (ADD..SLTU): opcode 0, rs, rt, rd, shamt 0, funct 0x20/0x22/0x24/0x25/0x2A/0x2B.
- MULT/MULTU/DIV/DIVU: opcode 0, rs, rt, rd=0, funct 0x18/0x19/0x1A/0x1B.
- MFHI/MFLO: rs=rt=0, rd, funct 0x10/0x12. MTHI/MTLO: rs only, funct 0x11/0x13. JR: rs only, funct 0x08.
- I-type ADDI/ANDI/ORI (0x08/0x0C/0x0D), LB/LH/LW (0x20/0x21/0x23), SB/SH/SW (0x28/0x29/0x2B), BEQ/BNE (0x04/0x05): opcode, rs, rt, imm[15:0].
- LUI (0x0F): rs forced 0. JAL (0x03): imm[25:0]. NOP: word 0.
- Any field unused by the op is forced to zero, whatever the input value.
- Legal accepted op: the encoded word is pushed. Illegal accepted op: no push; err is set.
- Pop on out_valid & out_ready. out_addr then advances by 4, wrapping modulo 2^32.

## Timing
- Reset values: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, FIFO empty, in_ready=1.
- Reset takes effect asynchronously. When rst_n asserts mid-stream, all buffered words are discarded immediately.
- in_ready = (count < DEPTH), combinational from count only. There is no full-bypass: while full, a same-cycle pop does not enable a push.
- Latency: a word accepted at edge N gives out_valid=1 after edge N, presenting the FIFO head.
- Simultaneous push and pop: count unchanged; order preserved.
- err is set at the edge that accepts an illegal op and holds until clear or reset.
- clear overrides push and pop in the same cycle. Words handshaken that cycle are dropped and out_addr is not advanced.
- out_instr and out_addr are stable while out_valid=1 and out_ready=0.

## Structure
- Shared package mips_instr_pkg: op enum, opcode and funct constants. The core decoder shares these constants.
- Sub-module instr_word_encoder: purely combinational (op, fields) → 32-bit word plus an illegal flag.
- Top level: FIFO (pointers, count), address counter and err flag.

## Test plan
- ADD rs=1 rt=2 rd=3 → out_instr 0x00221820, out_addr 0x3000, out_valid one cycle after accept.
- ORI rs=0 rt=1 imm=0x1234 → 0x34011234. LUI rs=7 rt=2 imm=0xFFFF → 0x3C02FFFF (rs ignored).
- SW rs=29 rt=31 imm=0xFFFC → 0xAFBFFFFC. JAL imm=0x0C00 → 0x0C000C00. JR rs=31 → 0x03E00008. MFLO rd=8 → 0x00004012. NOP → 0x00000000.
- Hold out_ready=0 and offer 5 words → in_ready=0 after the 4th is accepted. Release → words emerge in order at 0x3000, 0x3004, 0x3008, 0x300C, then the 5th at 0x3010.
- in_op=30 → handshake completes, no output, err=1 next cycle. Pulse clear → err=0, out_addr=0x3000, FIFO empty.
- 3 words buffered, rst_n low mid-cycle → out_valid=0 and out_addr=BASE_ADDR without waiting for a clock edge.
